// File: rtl/proc_pkg.sv
// Shared definitions for the instruction sequencer: opcode field values,
// sequencer state encoding and the instruction word width.
package proc_pkg;

  localparam int INSTR_W = 8;

  localparam logic [1:0] OP_MOV_TO_R0   = 2'b00;
  localparam logic [1:0] OP_MOV_FROM_R0 = 2'b01;
  localparam logic [1:0] OP_LDI         = 2'b10;
  localparam logic [1:0] OP_ALU         = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_ISSUE,
    ST_SETTLE,
    ST_FIN
  } seq_state_t;

  // Only ALU-class words need the processor to write back before the next word.
  function automatic logic needs_settle(input logic [1:0] opcode);
    return opcode == OP_ALU;
  endfunction

endpackage

// File: rtl/instr_sequencer_prog_mem.sv
// Program store: DEPTH x INSTR_W, one write port and one synchronous read port.
// The read register only updates on rd_en so it can drive sig directly.
module prog_mem
  import proc_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               we,
  input  logic [AW-1:0]      wr_addr,
  input  logic [INSTR_W-1:0] wr_data,
  input  logic               rd_en,
  input  logic [AW-1:0]      rd_addr,
  output logic [INSTR_W-1:0] rd_data
);

  logic [INSTR_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Holding the last read keeps the processor-facing word free of spurious changes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/instr_sequencer.sv
// Program sequencer feeding 8-bit instruction words to the register processor,
// with a valid/ready handshake and a settle gap after ALU-class instructions.
module instr_sequencer
  import proc_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int ALU_WAIT = 2,
  parameter int LOOP     = 0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       prog_we,
  input  logic [$clog2(DEPTH)-1:0]   prog_addr,
  input  logic [7:0]                 prog_data,
  input  logic [$clog2(DEPTH):0]     prog_len,
  input  logic                       start,
  input  logic                       stop,
  output logic [7:0]                 sig,
  output logic                       sig_valid,
  input  logic                       sig_ready,
  output logic                       busy,
  output logic                       done,
  output logic                       prog_err
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_L = (AW+1)'(DEPTH);
  localparam logic [3:0]  WAIT_L  = 4'(ALU_WAIT);

  seq_state_t    state, state_d;
  logic [AW-1:0] pc, pc_d;
  logic [AW:0]   len_q, len_d;
  logic [3:0]    cnt, cnt_d;
  logic          last_q, last_d;
  logic          stop_pend, stop_pend_d;
  logic          prog_err_d;
  logic          running, is_last, mem_we, mem_rd;
  logic          branch, branch_last;

  assign running   = (state == ST_FETCH) || (state == ST_ISSUE) || (state == ST_SETTLE);
  assign is_last   = ({1'b0, pc} + (AW+1)'(1)) == len_q;
  assign mem_we    = prog_we && (state == ST_IDLE);
  assign mem_rd    = (state == ST_FETCH);
  assign sig_valid = (state == ST_ISSUE);
  assign busy      = (state != ST_IDLE);
  assign done      = (state == ST_FIN);

  prog_mem #(.DEPTH(DEPTH)) u_mem (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (mem_we),
    .wr_addr (prog_addr),
    .wr_data (prog_data),
    .rd_en   (mem_rd),
    .rd_addr (pc),
    .rd_data (sig)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      pc        <= '0;
      len_q     <= '0;
      cnt       <= '0;
      last_q    <= 1'b0;
      stop_pend <= 1'b0;
      prog_err  <= 1'b0;
    end else begin
      state     <= state_d;
      pc        <= pc_d;
      len_q     <= len_d;
      cnt       <= cnt_d;
      last_q    <= last_d;
      stop_pend <= stop_pend_d;
      prog_err  <= prog_err_d;
    end
  end

  always_comb begin
    state_d     = state;
    pc_d        = pc;
    len_d       = len_q;
    cnt_d       = cnt;
    last_d      = last_q;
    stop_pend_d = stop_pend | (stop && running);
    prog_err_d  = prog_err | (prog_we && (state != ST_IDLE));
    branch      = 1'b0;
    branch_last = 1'b0;

    case (state)
      ST_IDLE: begin
        stop_pend_d = 1'b0;
        if (start) begin
          prog_err_d = 1'b0;
          if (prog_len == '0) begin
            state_d = ST_FIN;
          end else begin
            len_d   = (prog_len > DEPTH_L) ? DEPTH_L : prog_len;
            pc_d    = '0;
            state_d = ST_FETCH;
          end
        end
      end
      ST_FETCH: state_d = ST_ISSUE;
      ST_ISSUE: begin
        if (sig_ready) begin
          pc_d   = pc + AW'(1);
          last_d = is_last;
          if (needs_settle(sig[1:0]) && (WAIT_L != 4'd0)) begin
            cnt_d   = WAIT_L;
            state_d = ST_SETTLE;
          end else begin
            branch      = 1'b1;
            branch_last = is_last;
          end
        end
      end
      ST_SETTLE: begin
        if (cnt <= 4'd1) begin
          branch      = 1'b1;
          branch_last = last_q;
        end else begin
          cnt_d = cnt - 4'd1;
        end
      end
      ST_FIN: begin
        stop_pend_d = 1'b0;
        state_d     = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Common decision point after a handshake (or after its settle gap).
    if (branch) begin
      if (stop_pend) begin
        state_d = ST_FIN;
      end else if (branch_last) begin
        if (LOOP != 0) begin
          pc_d    = '0;
          state_d = ST_FETCH;
        end else begin
          state_d = ST_FIN;
        end
      end else begin
        state_d = ST_FETCH;
      end
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// Self-checking bench for instr_sequencer: a timing model derived from the
// handshake/settle rules predicts every output cycle by cycle.
module tb_instr_sequencer;

  localparam int DEPTH = 16;
  localparam int MAXC  = 256;
  localparam int W0    = 2;
  localparam int W1    = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       prog_we;
  logic [3:0] prog_addr;
  logic [7:0] prog_data;
  logic [4:0] prog_len;
  logic       start0, start1, stop, sig_ready;
  logic [7:0] sig0, sig1;
  logic       sig_valid0, sig_valid1, busy0, busy1, done0, done1, prog_err0, prog_err1;

  int checks = 0;
  int errors = 0;

  logic [7:0] image [DEPTH];
  bit         ready_pat [MAXC];
  logic [7:0] last_sig [2];
  bit         last_perr [2];
  logic [7:0] e_sig [MAXC];
  bit         e_valid [MAXC];
  bit         e_done [MAXC];
  bit         e_busy [MAXC];
  bit         e_perr [MAXC];

  always #5 clk = ~clk;

  instr_sequencer #(.DEPTH(DEPTH), .ALU_WAIT(W0), .LOOP(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .prog_len(prog_len), .start(start0), .stop(stop),
    .sig(sig0), .sig_valid(sig_valid0), .sig_ready(sig_ready), .busy(busy0),
    .done(done0), .prog_err(prog_err0)
  );

  instr_sequencer #(.DEPTH(DEPTH), .ALU_WAIT(W1), .LOOP(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .prog_we(prog_we), .prog_addr(prog_addr),
    .prog_data(prog_data), .prog_len(prog_len), .start(start1), .stop(stop),
    .sig(sig1), .sig_valid(sig_valid1), .sig_ready(sig_ready), .busy(busy1),
    .done(done1), .prog_err(prog_err1)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic load_memory();
    for (int i = 0; i < DEPTH; i++) begin
      @(posedge clk); #1;
      start0    = 1'b0;
      start1    = 1'b0;
      stop      = 1'b0;
      prog_we   = 1'b1;
      prog_addr = 4'(i);
      prog_data = image[i];
    end
    @(posedge clk); #1;
    prog_we = 1'b0;
  endtask

  // Start in cycle 0; first word valid in cycle 2; next word 2 (+wait if ALU) cycles
  // after each handshake; FIN one cycle after the last handshake/gap.
  task automatic build_model(input int which, input int len, input int nc,
                             input int stop_c, input int we_c);
    int  w, n, fin, t, h, gap, dec, idx;
    bit  lp, last, stop_taken, stalled;
    w       = (which == 1) ? W1 : W0;
    lp      = (which == 1);
    n       = (len > DEPTH) ? DEPTH : len;
    fin     = -1;
    stalled = 1'b0;
    for (int c = 0; c < nc; c++) begin
      e_sig[c] = last_sig[which]; e_valid[c] = 0; e_done[c] = 0; e_busy[c] = 0;
      e_perr[c] = (c == 0) ? last_perr[which] : 1'b0;
    end
    if (n == 0) begin
      fin = 1;
    end else begin
      t   = 2;
      idx = 0;
      while (fin < 0 && !stalled) begin
        h = t;
        while (h < nc && !ready_pat[h]) h++;
        for (int c = t; c < nc; c++) e_sig[c] = image[idx];
        for (int c = t; c <= h && c < nc; c++) e_valid[c] = 1'b1;
        if (h >= nc) begin
          stalled = 1'b1;
        end else begin
          gap        = (image[idx][1:0] == 2'b11) ? w : 0;
          dec        = h + gap;
          stop_taken = (stop_c >= 1) && (stop_c + 1 <= dec);
          last       = (idx == n - 1);
          if (stop_taken || (last && !lp)) begin
            fin = dec + 1;
          end else begin
            idx = last ? 0 : idx + 1;
            t   = dec + 2;
          end
        end
      end
    end
    for (int c = 1; c < nc; c++) begin
      if (fin < 0 || c <= fin) e_busy[c] = 1'b1;
    end
    if (fin >= 0 && fin < nc) e_done[fin] = 1'b1;
    if (we_c >= 0 && we_c < nc && e_busy[we_c]) begin
      for (int c = we_c + 1; c < nc; c++) e_perr[c] = 1'b1;
    end
  endtask

  task automatic applyStimulus(input int which, input int len, input int nc, input int stop_c,
                               input int we_c, input logic [3:0] we_addr, input logic [7:0] we_data);
    logic [7:0] o_sig;
    logic       o_valid, o_busy, o_done, o_perr;
    build_model(which, len, nc, stop_c, we_c);
    for (int c = 0; c < nc; c++) begin
      @(posedge clk); #1;
      start0    = (which == 0) && (c == 0);
      start1    = (which == 1) && (c == 0);
      prog_len  = 5'(len);
      stop      = (c == stop_c);
      sig_ready = ready_pat[c];
      prog_we   = (c == we_c);
      if (c == we_c) begin
        prog_addr = we_addr;
        prog_data = we_data;
      end
      @(negedge clk);
      o_sig   = (which == 1) ? sig1 : sig0;
      o_valid = (which == 1) ? sig_valid1 : sig_valid0;
      o_busy  = (which == 1) ? busy1 : busy0;
      o_done  = (which == 1) ? done1 : done0;
      o_perr  = (which == 1) ? prog_err1 : prog_err0;
      checkOutput($sformatf("d%0d_c%0d_valid", which, c), 32'(o_valid), 32'(e_valid[c]));
      checkOutput($sformatf("d%0d_c%0d_sig", which, c), 32'(o_sig), 32'(e_sig[c]));
      checkOutput($sformatf("d%0d_c%0d_busy", which, c), 32'(o_busy), 32'(e_busy[c]));
      checkOutput($sformatf("d%0d_c%0d_done", which, c), 32'(o_done), 32'(e_done[c]));
      checkOutput($sformatf("d%0d_c%0d_prog_err", which, c), 32'(o_perr), 32'(e_perr[c]));
    end
    last_sig[which]  = e_sig[nc-1];
    last_perr[which] = e_perr[nc-1];
  endtask

  task automatic ready_all();
    for (int c = 0; c < MAXC; c++) ready_pat[c] = 1'b1;
  endtask

  task automatic ready_random(input int until_c);
    for (int c = 0; c < MAXC; c++) ready_pat[c] = (c >= until_c) || ($urandom_range(0, 99) < 70);
  endtask

  task automatic randomize_image();
    for (int i = 0; i < DEPTH; i++) image[i] = 8'($urandom);
  endtask

  initial begin
    int len, stop_c, k;
    rst_n = 1'b0; prog_we = 1'b0; prog_addr = '0; prog_data = '0; prog_len = '0;
    start0 = 1'b0; start1 = 1'b0; stop = 1'b0; sig_ready = 1'b0;
    last_sig[0] = 8'h00; last_sig[1] = 8'h00; last_perr[0] = 1'b0; last_perr[1] = 1'b0;

    #1;
    checkOutput("reset_sig0", 32'(sig0), 32'h00);
    checkOutput("reset_valid0", 32'(sig_valid0), 32'h0);
    checkOutput("reset_busy0", 32'(busy0), 32'h0);
    checkOutput("reset_done0", 32'(done0), 32'h0);
    checkOutput("reset_err0", 32'(prog_err0), 32'h0);
    checkOutput("reset_sig1", 32'(sig1), 32'h00);
    checkOutput("reset_valid1", 32'(sig_valid1), 32'h0);
    checkOutput("reset_busy1", 32'(busy1), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] basic program, ready tied high");
    randomize_image();
    image[0] = 8'h56; image[1] = 8'h04; image[2] = 8'h23;
    load_memory();
    ready_all();
    applyStimulus(0, 3, 14, -1, -1, 4'd0, 8'h00);

    $display("[TB] ready held low for five cycles on the first word");
    for (int c = 2; c <= 6; c++) ready_pat[c] = 1'b0;
    applyStimulus(0, 3, 18, -1, -1, 4'd0, 8'h00);

    $display("[TB] zero-length program");
    ready_all();
    applyStimulus(0, 0, 6, -1, -1, 4'd0, 8'h00);

    $display("[TB] program write while busy is dropped and flagged");
    applyStimulus(0, 3, 14, -1, 3, 4'd1, 8'hFF);
    applyStimulus(0, 3, 14, -1, -1, 4'd0, 8'h00);

    $display("[TB] stop during the settle gap");
    image[3] = 8'h48;
    load_memory();
    applyStimulus(0, 4, 16, 7, -1, 4'd0, 8'h00);

    $display("[TB] program length clamped to depth");
    randomize_image();
    load_memory();
    applyStimulus(0, 20, 90, -1, -1, 4'd0, 8'h00);

    $display("[TB] randomized programs and ready patterns");
    for (int r = 0; r < 6; r++) begin
      randomize_image();
      load_memory();
      ready_random(150);
      len    = $urandom_range(0, 20);
      stop_c = ($urandom_range(0, 1) == 1) ? $urandom_range(1, 60) : -1;
      applyStimulus(0, len, 240, stop_c, -1, 4'd0, 8'h00);
    end

    $display("[TB] looping sequencer");
    image[0] = 8'h5A; image[1] = 8'h01;
    load_memory();
    ready_all();
    applyStimulus(1, 2, 20, 11, -1, 4'd0, 8'h00);
    randomize_image();
    load_memory();
    ready_random(60);
    applyStimulus(1, 3, 90, 40, -1, 4'd0, 8'h00);

    $display("[TB] reset while an instruction is being offered");
    image[0] = 8'h5A;
    load_memory();
    @(posedge clk); #1;
    start1 = 1'b1; prog_len = 5'd2; sig_ready = 1'b0; stop = 1'b0;
    @(posedge clk); #1;
    start1 = 1'b0;
    k = 0;
    while (!sig_valid1 && k < 10) begin
      @(negedge clk);
      k++;
    end
    checkOutput("rst_pre_valid1", 32'(sig_valid1), 32'h1);
    checkOutput("rst_pre_sig1", 32'(sig1), 32'h5A);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("rst_mid_sig1", 32'(sig1), 32'h00);
    checkOutput("rst_mid_valid1", 32'(sig_valid1), 32'h0);
    checkOutput("rst_mid_busy1", 32'(busy1), 32'h0);
    checkOutput("rst_mid_done1", 32'(done1), 32'h0);
    checkOutput("rst_mid_sig0", 32'(sig0), 32'h00);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("post_rst_done1", 32'(done1), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
